avalon_accel_csr: RTL and testbench
===================================

AVALON_ACCEL_CSR -- requirements
Module: avalon_accel_csr

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the Avalon data width; it is a multiple of 8.
REQ-002 Parameter KEY_WORDS, default 4, SHALL set the number of key registers.
REQ-003 Parameter MSG_WORDS, default 4, SHALL set the number of input and of output message registers.
REQ-004 Parameter TIMEOUT_CYC, default 1024, SHALL set the maximum engine run time in cycles; 0 disables the timeout.
REQ-005 Derived ADDR_W = clog2(KEY_WORDS+2*MSG_WORDS+2) SHALL size the address port.
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous active-high reset.
- AVL_READ  in  1  read strobe.
- AVL_WRITE  in  1  write strobe.
- AVL_CS  in  1  chip select.
- AVL_BYTE_EN  in  DATA_W/8  byte-lane enables.
- AVL_ADDR  in  ADDR_W  word address.
- AVL_WRITEDATA  in  DATA_W  write data.
- AVL_READDATA  out  DATA_W  read data, 1-cycle latency.
- ENG_START  out  1  one-cycle engine start pulse.
- ENG_KEY  out  KEY_WORDS*DATA_W  flattened key, word 0 in LSBs.
- ENG_MSG_IN  out  MSG_WORDS*DATA_W  flattened input message.
- ENG_DONE  in  1  one-cycle engine completion pulse.
- ENG_MSG_OUT  in  MSG_WORDS*DATA_W  engine result, valid while ENG_DONE is high.
- IRQ  out  1  level interrupt.
- EXPORT_DATA  out  DATA_W  conduit: {MSG_IN[MSG_WORDS-1] upper half, MSG_IN[0] lower half}.

Function
REQ-008 Map: KEY at 0..K-1, MSG_IN at K..K+M-1, MSG_OUT at K+M..K+2M-1, CTRL at K+2M, STATUS at K+2M+1 (K=KEY_WORDS, M=MSG_WORDS).
REQ-009 A write (AVL_WRITE&AVL_CS) SHALL update only the enabled byte lanes, for any byte-enable pattern; disabled lanes hold.
REQ-010 AVL_READDATA SHALL present the addressed register one cycle after AVL_READ&AVL_CS; otherwise 0.
REQ-011 Unmapped addresses SHALL read 0 and ignore writes; MSG_OUT is read-only.
REQ-012 CTRL: bit0 START (write-1 action, reads 0), bit1 IRQ_EN (read/write); other bits read 0.
REQ-013 STATUS: bit0 DONE, bit1 BUSY (read-only), bit2 LOCK_ERR, bit3 TIMEOUT; bits 0, 2, 3 sticky, write-1-to-clear.
REQ-014 FSM states IDLE, RUN.
- IDLE -> RUN on a START write; ENG_START pulses exactly one cycle, the cycle after the write; DONE and TIMEOUT are cleared.
- RUN -> IDLE on ENG_DONE: MSG_OUT <= ENG_MSG_OUT, DONE set.
- RUN -> IDLE when the run counter reaches TIMEOUT_CYC: TIMEOUT set, MSG_OUT unchanged.
REQ-015 BUSY SHALL equal (state==RUN).
REQ-016 A START write while in RUN SHALL be ignored and set LOCK_ERR.
REQ-017 KEY/MSG_IN writes while in RUN SHALL be ignored and set LOCK_ERR.
REQ-018 ENG_DONE while in IDLE SHALL be ignored.
REQ-019 The run counter SHALL be DATA_W bits, zeroed on entry to RUN, and incremented each RUN cycle without wrapping.
REQ-020 ENG_DONE in the terminal timeout cycle: done wins, and TIMEOUT stays clear.
REQ-021 A W1C in the same cycle as a hardware set of that bit: the set wins.
REQ-022 IRQ SHALL equal IRQ_EN & (DONE | TIMEOUT).

Reset
REQ-023 Asserting RESET SHALL immediately clear all registers, the counter and AVL_READDATA, and force the state to IDLE, including mid-run.
REQ-024 While RESET is asserted, ENG_START and IRQ SHALL be 0.

Structure
REQ-025 Package avl_csr_pkg SHALL hold the FSM state enum, the CTRL/STATUS bit-index constants and the address-offset functions of K and M.
REQ-026 Sub-module csr_be_merge SHALL perform byte-enable merging (old word, new word, enables -> merged word).

Verification
REQ-027 Defaults: write 32'hDEADBEEF to addr 0 with BE 4'b0101, after reset -> read returns 32'h00AD00EF.
REQ-028 Load key and message, write CTRL=3 -> ENG_START pulses once; ENG_DONE with result 0x11..; STATUS reads 1; IRQ=1; MSG_OUT reads the result.
REQ-029 In RUN, write addr 4 and CTRL=1 -> addr 4 unchanged, no second ENG_START, STATUS=32'h6.
REQ-030 TIMEOUT_CYC=8, no ENG_DONE -> IDLE after 8 RUN cycles, STATUS=32'h8; write STATUS=8 -> reads 0.
REQ-031 ENG_DONE in the timeout cycle plus a same-cycle STATUS W1C of bit0 -> STATUS=1.
REQ-032 RESET asserted mid-RUN -> BUSY=0, all registers 0 at once; a later START runs normally.

Source files
------------

// File: rtl/avl_csr_pkg.sv
// Shared definitions for the Avalon accelerator CSR block: FSM encoding,
// CTRL/STATUS bit positions and the register-map offset helpers.
package avl_csr_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int CTRL_START_BIT    = 0;
   localparam int CTRL_IRQ_EN_BIT   = 1;

   localparam int STAT_DONE_BIT     = 0;
   localparam int STAT_BUSY_BIT     = 1;
   localparam int STAT_LOCK_ERR_BIT = 2;
   localparam int STAT_TIMEOUT_BIT  = 3;

   localparam int KEY_BASE = 0;

   function automatic int msg_in_base(input int k);
      return k;
   endfunction

   function automatic int msg_out_base(input int k, input int m);
      return k + m;
   endfunction

   function automatic int ctrl_addr(input int k, input int m);
      return k + 2 * m;
   endfunction

   function automatic int status_addr(input int k, input int m);
      return k + 2 * m + 1;
   endfunction

endpackage

// File: rtl/csr_be_merge.sv
// Byte-lane merge: each enabled lane takes the new byte, the rest keep the old word.
module csr_be_merge #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_word,
   input  logic [DATA_W-1:0]   new_word,
   input  logic [DATA_W/8-1:0] byte_en,
   output logic [DATA_W-1:0]   merged
);

   always_comb begin
      merged = old_word;
      for (int b = 0; b < DATA_W / 8; b++) begin
         if (byte_en[b]) merged[8*b +: 8] = new_word[8*b +: 8];
      end
   end

endmodule

// File: rtl/avalon_accel_csr.sv
// Avalon-MM register front end for a key/message accelerator engine: holds the
// key and message words, launches runs, captures results and reports status.
module avalon_accel_csr
   import avl_csr_pkg::*;
#(
   parameter  int DATA_W      = 32,
   parameter  int KEY_WORDS   = 4,
   parameter  int MSG_WORDS   = 4,
   parameter  int TIMEOUT_CYC = 1024,
   localparam int ADDR_W      = $clog2(KEY_WORDS + 2 * MSG_WORDS + 2)
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          AVL_READ,
   input  logic                          AVL_WRITE,
   input  logic                          AVL_CS,
   input  logic [DATA_W/8-1:0]           AVL_BYTE_EN,
   input  logic [ADDR_W-1:0]             AVL_ADDR,
   input  logic [DATA_W-1:0]             AVL_WRITEDATA,
   output logic [DATA_W-1:0]             AVL_READDATA,
   output logic                          ENG_START,
   output logic [KEY_WORDS*DATA_W-1:0]   ENG_KEY,
   output logic [MSG_WORDS*DATA_W-1:0]   ENG_MSG_IN,
   input  logic                          ENG_DONE,
   input  logic [MSG_WORDS*DATA_W-1:0]   ENG_MSG_OUT,
   output logic                          IRQ,
   output logic [DATA_W-1:0]             EXPORT_DATA
);

   localparam int A_MSG_IN  = msg_in_base(KEY_WORDS);
   localparam int A_MSG_OUT = msg_out_base(KEY_WORDS, MSG_WORDS);
   localparam int A_CTRL    = ctrl_addr(KEY_WORDS, MSG_WORDS);
   localparam int A_STATUS  = status_addr(KEY_WORDS, MSG_WORDS);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] key_q[KEY_WORDS], key_d[KEY_WORDS];
   logic [DATA_W-1:0] msg_in_q[MSG_WORDS], msg_in_d[MSG_WORDS];
   logic [DATA_W-1:0] msg_out_q[MSG_WORDS], msg_out_d[MSG_WORDS];
   logic              irq_en_q, irq_en_d;
   logic              done_q, done_d;
   logic              lock_err_q, lock_err_d;
   logic              timeout_q, timeout_d;
   logic              eng_start_q, eng_start_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   int                addr_i;
   logic              wr_en, rd_en, running, start_go, lock_set;
   logic [DATA_W-1:0] rd_word, wr_merged, wr_mask, cnt_inc;

   assign addr_i  = int'(AVL_ADDR);
   assign wr_en   = AVL_WRITE & AVL_CS;
   assign rd_en   = AVL_READ & AVL_CS;
   assign running = (state_q == ST_RUN);

   // Current value of the addressed register; unmapped addresses fall through to 0.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < KEY_WORDS; i++) begin
         if (addr_i == KEY_BASE + i) rd_word = key_q[i];
      end
      for (int i = 0; i < MSG_WORDS; i++) begin
         if (addr_i == A_MSG_IN + i)  rd_word = msg_in_q[i];
         if (addr_i == A_MSG_OUT + i) rd_word = msg_out_q[i];
      end
      if (addr_i == A_CTRL) rd_word[CTRL_IRQ_EN_BIT] = irq_en_q;
      if (addr_i == A_STATUS) begin
         rd_word[STAT_DONE_BIT]     = done_q;
         rd_word[STAT_BUSY_BIT]     = running;
         rd_word[STAT_LOCK_ERR_BIT] = lock_err_q;
         rd_word[STAT_TIMEOUT_BIT]  = timeout_q;
      end
   end

   csr_be_merge #(.DATA_W(DATA_W)) u_merge (
      .old_word (rd_word),
      .new_word (AVL_WRITEDATA),
      .byte_en  (AVL_BYTE_EN),
      .merged   (wr_merged)
   );

   // Lane-masked write data: action bits (START, W1C) only fire on enabled lanes.
   csr_be_merge #(.DATA_W(DATA_W)) u_mask (
      .old_word ('0),
      .new_word (AVL_WRITEDATA),
      .byte_en  (AVL_BYTE_EN),
      .merged   (wr_mask)
   );

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      msg_in_d    = msg_in_q;
      msg_out_d   = msg_out_q;
      irq_en_d    = irq_en_q;
      done_d      = done_q;
      lock_err_d  = lock_err_q;
      timeout_d   = timeout_q;
      eng_start_d = 1'b0;
      rdata_d     = rd_en ? rd_word : '0;
      start_go    = 1'b0;
      lock_set    = 1'b0;

      if (wr_en) begin
         for (int i = 0; i < KEY_WORDS; i++) begin
            if (addr_i == KEY_BASE + i) begin
               if (running) lock_set = 1'b1;
               else         key_d[i] = wr_merged;
            end
         end
         for (int i = 0; i < MSG_WORDS; i++) begin
            if (addr_i == A_MSG_IN + i) begin
               if (running) lock_set    = 1'b1;
               else         msg_in_d[i] = wr_merged;
            end
         end
         if (addr_i == A_CTRL) begin
            irq_en_d = wr_merged[CTRL_IRQ_EN_BIT];
            if (wr_mask[CTRL_START_BIT]) begin
               if (running) lock_set = 1'b1;
               else         start_go = 1'b1;
            end
         end
         if (addr_i == A_STATUS) begin
            if (wr_mask[STAT_DONE_BIT])     done_d     = 1'b0;
            if (wr_mask[STAT_LOCK_ERR_BIT]) lock_err_d = 1'b0;
            if (wr_mask[STAT_TIMEOUT_BIT])  timeout_d  = 1'b0;
         end
      end

      // Hardware sets are applied after the W1C clears so they win a collision.
      if (lock_set) lock_err_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (start_go) begin
               state_d     = ST_RUN;
               cnt_d       = '0;
               eng_start_d = 1'b1;
               done_d      = 1'b0;
               timeout_d   = 1'b0;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_inc;
            if (ENG_DONE) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               for (int i = 0; i < MSG_WORDS; i++) begin
                  msg_out_d[i] = ENG_MSG_OUT[i*DATA_W +: DATA_W];
               end
            end else if (TIMEOUT_CYC != 0 && cnt_inc == DATA_W'(TIMEOUT_CYC)) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         lock_err_q  <= 1'b0;
         timeout_q   <= 1'b0;
         eng_start_q <= 1'b0;
         rdata_q     <= '0;
         for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
         for (int i = 0; i < MSG_WORDS; i++) begin
            msg_in_q[i]  <= '0;
            msg_out_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         lock_err_q  <= lock_err_d;
         timeout_q   <= timeout_d;
         eng_start_q <= eng_start_d;
         rdata_q     <= rdata_d;
         key_q       <= key_d;
         msg_in_q    <= msg_in_d;
         msg_out_q   <= msg_out_d;
      end
   end

   always_comb begin
      ENG_KEY    = '0;
      ENG_MSG_IN = '0;
      for (int i = 0; i < KEY_WORDS; i++) ENG_KEY[i*DATA_W +: DATA_W] = key_q[i];
      for (int i = 0; i < MSG_WORDS; i++) ENG_MSG_IN[i*DATA_W +: DATA_W] = msg_in_q[i];
   end

   assign EXPORT_DATA  = {msg_in_q[MSG_WORDS-1][DATA_W-1:DATA_W/2], msg_in_q[0][DATA_W/2-1:0]};
   assign AVL_READDATA = rdata_q;
   assign ENG_START    = eng_start_q;
   assign IRQ          = irq_en_q & (done_q | timeout_q);

endmodule

// File: tb/tb_avalon_accel_csr.sv
// Self-checking bench for avalon_accel_csr: register access, engine runs,
// lock errors, timeout boundary and asynchronous reset.
module tb_avalon_accel_csr;

   localparam int DW = 32;
   localparam int KW = 4;
   localparam int MW = 4;
   localparam int TO = 8;
   localparam int AW = 4;
   localparam int BW = DW / 8;
   localparam int A_MIN  = 4;
   localparam int A_MOUT = 8;
   localparam int A_CTRL = 12;
   localparam int A_STAT = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          avl_read, avl_write, avl_cs;
   logic [BW-1:0] avl_be;
   logic [AW-1:0] avl_addr;
   logic [DW-1:0] avl_wdata, avl_rdata;
   logic          eng_start, eng_done, irq;
   logic [KW*DW-1:0] eng_key;
   logic [MW*DW-1:0] eng_msg_in, eng_msg_out;
   logic [DW-1:0] export_data;

   int tests_run = 0;
   int fails     = 0;
   int start_cnt = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] key_m[KW];
   logic [DW-1:0] msg_m[MW];
   logic [DW-1:0] mo_m[MW];

   avalon_accel_csr #(
      .DATA_W(DW), .KEY_WORDS(KW), .MSG_WORDS(MW), .TIMEOUT_CYC(TO)
   ) dut (
      .CLK(clk), .RESET(rst),
      .AVL_READ(avl_read), .AVL_WRITE(avl_write), .AVL_CS(avl_cs),
      .AVL_BYTE_EN(avl_be), .AVL_ADDR(avl_addr), .AVL_WRITEDATA(avl_wdata),
      .AVL_READDATA(avl_rdata), .ENG_START(eng_start), .ENG_KEY(eng_key),
      .ENG_MSG_IN(eng_msg_in), .ENG_DONE(eng_done), .ENG_MSG_OUT(eng_msg_out),
      .IRQ(irq), .EXPORT_DATA(export_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (eng_start === 1'b1) start_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] be_apply(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                              input logic [BW-1:0] be);
      be_apply = o;
      for (int b = 0; b < BW; b++) if (be[b]) be_apply[8*b +: 8] = n[8*b +: 8];
   endfunction

   task automatic clear_models();
      for (int i = 0; i < KW; i++) key_m[i] = '0;
      for (int i = 0; i < MW; i++) begin
         msg_m[i] = '0;
         mo_m[i]  = '0;
      end
   endtask

   // Drivers: called at a falling edge, return at the next falling edge.
   task automatic bus_wr(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
      avl_write = 1'b1; avl_cs = 1'b1; avl_addr = AW'(a); avl_wdata = d; avl_be = be;
      @(negedge clk);
      avl_write = 1'b0; avl_cs = 1'b0; avl_be = '0;
   endtask

   task automatic bus_rd(input int a, output logic [DW-1:0] d);
      avl_read = 1'b1; avl_cs = 1'b1; avl_addr = AW'(a);
      @(negedge clk);
      d = avl_rdata;
      avl_read = 1'b0; avl_cs = 1'b0;
   endtask

   task automatic pulse_done(input logic [MW*DW-1:0] res);
      eng_done = 1'b1; eng_msg_out = res;
      @(negedge clk);
      eng_done = 1'b0; eng_msg_out = {MW{32'h0BAD_0BAD}};
   endtask

   task automatic test_reset();
      logic [DW-1:0] got, exp;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (eng_start !== 1'b0 || irq !== 1'b0 || avl_rdata !== '0) begin
         fails++;
         $display("FAIL reset_outputs: start=%b irq=%b rdata=%h, need 0/0/0", eng_start, irq, avl_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
      clear_models();
      for (int a = 0; a < 16; a++) begin
         exp_q.push_back('0);
         bus_rd(a, got);
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            fails++;
            $display("FAIL reset_read[%0d]: got %h need %h", a, got, exp);
         end
      end
   endtask

   task automatic test_byte_enable();
      logic [DW-1:0] got, exp, d;
      logic [BW-1:0] be;
      int a;
      bus_wr(0, 32'hDEADBEEF, 4'b0101);
      key_m[0] = be_apply(key_m[0], 32'hDEADBEEF, 4'b0101);
      exp_q.push_back(32'h00AD00EF);
      bus_rd(0, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL be_0101: got %h need %h", got, exp);
      end
      bus_wr(0, 32'hCAFEF00D, 4'b1010);
      key_m[0] = be_apply(key_m[0], 32'hCAFEF00D, 4'b1010);
      exp_q.push_back(32'hCAADF0EF);
      bus_rd(0, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL be_1010: got %h need %h", got, exp);
      end
      for (int n = 0; n < 24; n++) begin
         a  = $urandom_range(0, 7);
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         bus_wr(a, d, be);
         if (a < KW) key_m[a] = be_apply(key_m[a], d, be);
         else        msg_m[a-KW] = be_apply(msg_m[a-KW], d, be);
      end
      // Full-lane writes so every word ends up with a known value.
      for (int i = 0; i < KW; i++) begin
         d = $urandom;
         bus_wr(i, d, 4'hF);
         key_m[i] = d;
      end
      for (int i = 0; i < MW; i++) begin
         d = be_apply(msg_m[i], $urandom, 4'($urandom_range(1, 15)));
         bus_wr(A_MIN + i, d, 4'hF);
         msg_m[i] = d;
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] got, exp;
      logic [KW*DW-1:0] ek;
      logic [MW*DW-1:0] em;
      int aa;
      avl_read = 1'b1; avl_cs = 1'b1;
      for (int n = 0; n < 10; n++) begin
         aa = (n < 8) ? n : n + 6;
         if (aa < KW)      exp_q.push_back(key_m[aa]);
         else if (aa < 8)  exp_q.push_back(msg_m[aa-KW]);
         else              exp_q.push_back('0);
         avl_addr = AW'(aa);
         @(negedge clk);
         got = avl_rdata;
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            fails++;
            $display("FAIL b2b_read[%0d]: got %h need %h", aa, got, exp);
         end
      end
      avl_read = 1'b0; avl_cs = 1'b0;
      @(negedge clk);
      tests_run++;
      if (avl_rdata !== '0) begin
         fails++;
         $display("FAIL idle_readdata: got %h need 0", avl_rdata);
      end
      for (int i = 0; i < KW; i++) ek[i*DW +: DW] = key_m[i];
      for (int i = 0; i < MW; i++) em[i*DW +: DW] = msg_m[i];
      tests_run++;
      if (eng_key !== ek || eng_msg_in !== em) begin
         fails++;
         $display("FAIL eng_vectors: key %h msg %h need key %h msg %h", eng_key, eng_msg_in, ek, em);
      end
      tests_run++;
      if (export_data !== {msg_m[MW-1][31:16], msg_m[0][15:0]}) begin
         fails++;
         $display("FAIL export_data: got %h need %h", export_data, {msg_m[MW-1][31:16], msg_m[0][15:0]});
      end
   endtask

   task automatic test_unmapped_ctrl();
      logic [DW-1:0] got, exp;
      bus_wr(14, 32'h12345678, 4'hF);
      bus_wr(A_MOUT, 32'hFFFFFFFF, 4'hF);
      exp_q.push_back('0);
      exp_q.push_back(mo_m[0]);
      bus_rd(14, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL unmapped_read: got %h need %h", got, exp);
      end
      bus_rd(A_MOUT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL msg_out_readonly: got %h need %h", got, exp);
      end
      bus_wr(A_CTRL, 32'hFFFFFFFE, 4'hF);
      exp_q.push_back(32'h2);
      bus_rd(A_CTRL, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL ctrl_bits: got %h need %h", got, exp);
      end
      tests_run++;
      if (start_cnt !== 0) begin
         fails++;
         $display("FAIL no_spurious_start: got %0d pulses need 0", start_cnt);
      end
      bus_wr(A_CTRL, 32'h0, 4'hF);
   endtask

   task automatic test_run_done();
      logic [DW-1:0] got, exp;
      int s0;
      s0 = start_cnt;
      bus_wr(A_CTRL, 32'h3, 4'hF);
      tests_run++;
      if (eng_start !== 1'b1) begin
         fails++;
         $display("FAIL start_pulse_hi: got %b need 1", eng_start);
      end
      @(negedge clk);
      tests_run++;
      if (eng_start !== 1'b0) begin
         fails++;
         $display("FAIL start_pulse_lo: got %b need 0", eng_start);
      end
      exp_q.push_back(32'h2);
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL status_busy: got %h need %h", got, exp);
      end
      for (int i = 0; i < MW; i++) mo_m[i] = {8{4'(i + 1)}};
      pulse_done({mo_m[3], mo_m[2], mo_m[1], mo_m[0]});
      exp_q.push_back(32'h1);
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL status_done: got %h need %h", got, exp);
      end
      tests_run++;
      if (irq !== 1'b1 || start_cnt - s0 !== 1) begin
         fails++;
         $display("FAIL done_irq: irq=%b pulses=%0d need 1/1", irq, start_cnt - s0);
      end
      for (int i = 0; i < MW; i++) begin
         exp_q.push_back(mo_m[i]);
         bus_rd(A_MOUT + i, got);
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            fails++;
            $display("FAIL msg_out[%0d]: got %h need %h", i, got, exp);
         end
      end
      pulse_done({MW{32'hFEEDFACE}});
      exp_q.push_back(mo_m[0]);
      bus_rd(A_MOUT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL idle_done_ignored: got %h need %h", got, exp);
      end
   endtask

   task automatic test_lock();
      logic [DW-1:0] got, exp;
      int s0;
      s0 = start_cnt;
      bus_wr(A_CTRL, 32'h3, 4'hF);
      bus_wr(A_MIN, 32'h12345678, 4'hF);
      bus_wr(A_CTRL, 32'h1, 4'hF);
      exp_q.push_back(32'h6);
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL lock_status: got %h need %h", got, exp);
      end
      exp_q.push_back(msg_m[0]);
      bus_rd(A_MIN, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL lock_msg_hold: got %h need %h", got, exp);
      end
      for (int i = 0; i < MW; i++) mo_m[i] = 32'hA0A0_0000 + i;
      pulse_done({mo_m[3], mo_m[2], mo_m[1], mo_m[0]});
      tests_run++;
      if (start_cnt - s0 !== 1 || irq !== 1'b0) begin
         fails++;
         $display("FAIL lock_single_start: pulses=%0d irq=%b need 1/0", start_cnt - s0, irq);
      end
      exp_q.push_back(32'h5);
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL lock_sticky: got %h need %h", got, exp);
      end
      bus_wr(A_STAT, 32'h5, 4'hF);
      exp_q.push_back(32'h0);
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL lock_w1c: got %h need %h", got, exp);
      end
   endtask

   task automatic test_timeout();
      logic [DW-1:0] got, exp;
      bus_wr(A_CTRL, 32'h1, 4'hF);
      repeat (TO - 1) @(negedge clk);
      exp_q.push_back(32'h2);
      exp_q.push_back(32'h8);
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL timeout_last_run_cycle: got %h need %h", got, exp);
      end
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL timeout_status: got %h need %h", got, exp);
      end
      bus_wr(A_CTRL, 32'h2, 4'hF);
      tests_run++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL timeout_irq: got %b need 1", irq);
      end
      bus_wr(A_STAT, 32'h8, 4'hF);
      exp_q.push_back(32'h0);
      exp_q.push_back(mo_m[0]);
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp || irq !== 1'b0) begin
         fails++;
         $display("FAIL timeout_w1c: got %h irq=%b need %h irq=0", got, irq, exp);
      end
      bus_rd(A_MOUT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL timeout_msg_out_hold: got %h need %h", got, exp);
      end
   endtask

   task automatic test_done_at_timeout();
      logic [DW-1:0] got, exp;
      bus_wr(A_CTRL, 32'h3, 4'hF);
      repeat (TO - 1) @(negedge clk);
      for (int i = 0; i < MW; i++) mo_m[i] = 32'h5A5A_0000 + i;
      eng_done = 1'b1;
      eng_msg_out = {mo_m[3], mo_m[2], mo_m[1], mo_m[0]};
      bus_wr(A_STAT, 32'h1, 4'hF);
      eng_done = 1'b0;
      exp_q.push_back(32'h1);
      exp_q.push_back(mo_m[3]);
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp || irq !== 1'b1) begin
         fails++;
         $display("FAIL done_wins_timeout: got %h irq=%b need %h irq=1", got, irq, exp);
      end
      bus_rd(A_MOUT + 3, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL done_at_timeout_msg: got %h need %h", got, exp);
      end
      bus_wr(A_STAT, 32'h1, 4'hF);
   endtask

   task automatic test_reset_mid_run();
      logic [DW-1:0] got, exp;
      bus_wr(0, 32'hA5A55A5A, 4'hF);
      key_m[0] = 32'hA5A55A5A;
      bus_wr(A_CTRL, 32'h1, 4'hF);
      avl_read = 1'b1; avl_cs = 1'b1; avl_addr = AW'(0);
      @(posedge clk);
      #2;
      tests_run++;
      if (avl_rdata !== key_m[0]) begin
         fails++;
         $display("FAIL pre_reset_read: got %h need %h", avl_rdata, key_m[0]);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (avl_rdata !== '0 || eng_key !== '0 || export_data !== '0 || eng_start !== 1'b0 || irq !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: rdata %h key %h export %h start %b irq %b need all 0",
                  avl_rdata, eng_key, export_data, eng_start, irq);
      end
      avl_read = 1'b0; avl_cs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (eng_start !== 1'b0 || irq !== 1'b0) begin
         fails++;
         $display("FAIL reset_held_outputs: start %b irq %b need 0/0", eng_start, irq);
      end
      rst = 1'b0;
      clear_models();
      @(negedge clk);
      exp_q.push_back(32'h0);
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL reset_status_idle: got %h need %h", got, exp);
      end
      bus_wr(A_CTRL, 32'h3, 4'hF);
      tests_run++;
      if (eng_start !== 1'b1) begin
         fails++;
         $display("FAIL restart_pulse: got %b need 1", eng_start);
      end
      mo_m[0] = 32'h77777777;
      pulse_done({{(MW-1){32'h0}}, mo_m[0]});
      exp_q.push_back(32'h1);
      bus_rd(A_STAT, got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp || irq !== 1'b1) begin
         fails++;
         $display("FAIL restart_done: got %h irq=%b need %h irq=1", got, irq, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      avl_read = 1'b0; avl_write = 1'b0; avl_cs = 1'b0;
      avl_be = '0; avl_addr = '0; avl_wdata = '0;
      eng_done = 1'b0; eng_msg_out = '0;
      clear_models();
      @(negedge clk);
      test_reset();
      test_byte_enable();
      test_back_to_back();
      test_unmapped_ctrl();
      test_run_done();
      test_lock();
      test_timeout();
      test_done_at_timeout();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
